// File: rtl/adc_pkg.sv
// adc_pkg: capture FSM states and constants shared by the ADC capture block.
package adc_pkg;

    localparam int LEAD_DEFAULT = 2;
    // Extra accumulator bits: room for up to 2^7 frames of full-scale samples.
    localparam int ACC_HEADROOM = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_e;

endpackage

// File: rtl/adc_lane.sv
// adc_lane: one converter lane -- serial shift-in, sample register,
// window accumulator/mean and sticky over-limit flag.
module adc_lane
    import adc_pkg::*;
#(
    parameter int BITS = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sdata_i,
    input  logic            shift_en_i,
    input  logic            load_i,
    input  logic            acc_en_i,
    input  logic            win_last_i,
    input  logic            win_clr_i,
    input  logic [2:0]      lg_i,
    input  logic [BITS-1:0] limit_i,
    input  logic            clear_i,
    output logic [BITS-1:0] sample_o,
    output logic [BITS-1:0] avg_o,
    output logic            over_o
);

    logic [BITS-1:0]              sh_q, sh_d, smp_q, avg_q;
    logic [BITS+ACC_HEADROOM-1:0] acc_q, acc_sum;
    logic                         over_q, trip_q, trip;

    // Next shift value, trip decision on the completed word, running sum
    always_comb begin
        sh_d    = {sh_q[BITS-2:0], sdata_i};
        trip    = load_i && (sh_d > limit_i);
        acc_sum = acc_q + {{ACC_HEADROOM{1'b0}}, smp_q};
    end

    // Shift register, sample, limit flag and averaging state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_q   <= '0;
            smp_q  <= '0;
            avg_q  <= '0;
            acc_q  <= '0;
            over_q <= 1'b0;
            trip_q <= 1'b0;
        end else begin
            if (shift_en_i) sh_q <= sh_d;
            if (load_i) smp_q <= sh_d;
            // trip_q also blocks a clear in the sample_valid cycle itself,
            // so a trip always survives a coincident clear
            trip_q <= trip;
            if (trip) over_q <= 1'b1;
            else if (clear_i && !trip_q) over_q <= 1'b0;
            if (win_clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                if (win_last_i) begin
                    acc_q <= '0;
                    avg_q <= BITS'(acc_sum >> lg_i);
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    assign sample_o = smp_q;
    assign avg_o    = avg_q;
    assign over_o   = over_q;

endmodule

// File: rtl/adc_capture_mc.sv
// adc_capture_mc: periodic multi-lane serial ADC frame capture with
// windowed averaging and per-lane over-limit detection.
module adc_capture_mc
    import adc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int BITS   = 12,
    parameter int LEAD   = LEAD_DEFAULT,
    parameter int PERIOD = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   ad_cs,
    input  logic [NUM_CH-1:0]      ad_sdata,
    output logic [NUM_CH*BITS-1:0] sample_data,
    output logic                   sample_valid,
    input  logic [2:0]             avg_log2,
    output logic [NUM_CH*BITS-1:0] avg_data,
    output logic                   avg_valid,
    input  logic [NUM_CH*BITS-1:0] limit,
    output logic [NUM_CH-1:0]      over_limit,
    input  logic                   clear_limit
);

    localparam int CW = $clog2(PERIOD);

    if (PERIOD < LEAD + BITS + 2) begin : g_period_check
        $error("adc_capture_mc: PERIOD must be at least LEAD+BITS+2");
    end

    adc_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, ph_q, ph_d;
    logic            cs_q, sv_q, av_q;
    logic            shift_en, load;
    logic [7:0]      win_q;
    logic [2:0]      lg_q, eff_lg;
    logic            win_last, win_clr;

    // Frame FSM; ph counts frame cycles so a frame finishes even if enable drops
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        shift_en = 1'b0;
        load     = 1'b0;
        cnt_d    = '0;
        if (enable) cnt_d = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (enable && cnt_q == '0) begin
                    ph_d    = CW'(1);
                    state_d = (LEAD == 0) ? ST_SHIFT : ST_LEAD;
                end
            end
            ST_LEAD: begin
                ph_d = ph_q + CW'(1);
                if (ph_q == CW'(LEAD)) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                ph_d     = ph_q + CW'(1);
                if (ph_q == CW'(LEAD + BITS)) begin
                    load    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ph_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Window bookkeeping; the first frame of a window uses avg_log2 live
    always_comb begin
        eff_lg   = (win_q == '0) ? avg_log2 : lg_q;
        win_last = (win_q + 8'd1) == (8'd1 << eff_lg);
        win_clr  = !enable && (state_q == ST_IDLE);
    end

    // FSM, period counter, chip select and sample strobe registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            cs_q    <= 1'b1;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            cs_q    <= !(state_d == ST_LEAD || state_d == ST_SHIFT);
            sv_q    <= load;
        end
    end

    // Averaging window frame count and latched window size
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_q <= '0;
            lg_q  <= '0;
            av_q  <= 1'b0;
        end else begin
            av_q <= sv_q && win_last;
            if (win_clr) begin
                win_q <= '0;
            end else if (sv_q) begin
                if (win_q == '0) lg_q <= avg_log2;
                win_q <= win_last ? '0 : win_q + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        adc_lane #(.BITS(BITS)) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .sdata_i    (ad_sdata[i]),
            .shift_en_i (shift_en),
            .load_i     (load),
            .acc_en_i   (sv_q),
            .win_last_i (win_last),
            .win_clr_i  (win_clr),
            .lg_i       (eff_lg),
            .limit_i    (limit[i*BITS +: BITS]),
            .clear_i    (clear_limit),
            .sample_o   (sample_data[i*BITS +: BITS]),
            .avg_o      (avg_data[i*BITS +: BITS]),
            .over_o     (over_limit[i])
        );
    end

    assign ad_cs        = cs_q;
    assign sample_valid = sv_q;
    assign avg_valid    = av_q;

endmodule
